// File: rtl/renesas_gpio_axil_bridge_if.sv
// AXI4-Lite channel bundle between the board interconnect and the
// GPIO register bridge.
interface renesas_gpio_axil_bridge_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/renesas_gpio_axil_bridge.sv
// AXI4-Lite slave turning host accesses into the single-cycle
// sys_if strobe bus of the GPIO register bank, one access at a time.
module renesas_gpio_axil_bridge #(
    parameter logic [31:0] ADDR_SPAN = 32'h40
) (
    input  logic                             sys_if_clk,
    input  logic                             sys_if_rstn,
    renesas_gpio_axil_bridge_if.slave        s_axil,
    output logic                             sys_if_wen,
    output logic [31:0]                      sys_if_addr,
    output logic [31:0]                      sys_if_wdata,
    input  logic [31:0]                      sys_if_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_STROBE,
        WR_RESP,
        RD_ADDR,
        RD_CAPTURE,
        RD_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_e      state_q;
    logic        last_wr_q;
    logic        err_q;
    logic        wen_q;
    logic        bvalid_q;
    logic        rvalid_q;
    logic [1:0]  bresp_q;
    logic [1:0]  rresp_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic wr_req;
    logic rd_req;
    logic idle;
    logic grant_w;
    logic grant_r;
    logic wr_err;
    logic rd_err;

    // Readys are combinational grants, gated by reset so they read 0 in reset.
    always_comb begin
        wr_req  = s_axil.awvalid & s_axil.wvalid;
        rd_req  = s_axil.arvalid;
        idle    = (state_q == IDLE) & sys_if_rstn;
        grant_w = idle & wr_req & (~rd_req | ~last_wr_q);
        grant_r = idle & rd_req & ~grant_w;
        wr_err  = (s_axil.awaddr >= ADDR_SPAN) |
                  (s_axil.wstrb != 4'hF);
        rd_err  = (s_axil.araddr >= ADDR_SPAN);
    end

    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_w) begin
                        addr_q    <= {s_axil.awaddr[31:2], 2'b00};
                        wdata_q   <= s_axil.wdata;
                        err_q     <= wr_err;
                        wen_q     <= ~wr_err;
                        last_wr_q <= 1'b1;
                        state_q   <= WR_STROBE;
                    end else if (grant_r) begin
                        addr_q    <= {s_axil.araddr[31:2], 2'b00};
                        err_q     <= rd_err;
                        last_wr_q <= 1'b0;
                        state_q   <= RD_ADDR;
                    end
                end
                WR_STROBE: begin
                    wen_q    <= 1'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    state_q  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axil.bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_ADDR: begin
                    state_q <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    rdata_q  <= err_q ? 32'h0 : sys_if_rdata;
                    rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    rvalid_q <= 1'b1;
                    state_q  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axil.rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_axil.awready = grant_w;
    assign s_axil.wready  = grant_w;
    assign s_axil.arready = grant_r;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;
    assign sys_if_wen     = wen_q;
    assign sys_if_addr    = addr_q;
    assign sys_if_wdata   = wdata_q;

endmodule

// File: tb/tb_renesas_gpio_axil_bridge.sv
// Directed bench for the GPIO AXI4-Lite bridge with a small
// register-bank model on the sys_if side.
module tb_renesas_gpio_axil_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    renesas_gpio_axil_bridge_if axil();

    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] mem [16] = '{10: 32'h3F, default: 32'h0};

    int vectors = 0;
    int errs = 0;
    int bcnt = 0;
    int rcnt = 0;
    int wen_in_rst = 0;

    renesas_gpio_axil_bridge #(.ADDR_SPAN(32'h40)) dut (
        .sys_if_clk   (clk),
        .sys_if_rstn  (rst_n),
        .s_axil       (axil),
        .sys_if_wen   (wen),
        .sys_if_addr  (addr),
        .sys_if_wdata (wdata),
        .sys_if_rdata (rdata)
    );

    assign rdata = mem[addr[5:2]];

    always @(posedge clk) begin
        if (wen) mem[addr[5:2]] <= wdata;
        if (axil.bvalid && axil.bready) bcnt <= bcnt + 1;
        if (axil.rvalid && axil.rready) rcnt <= rcnt + 1;
        if (!rst_n && wen) wen_in_rst <= wen_in_rst + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_wen,
                            input logic [1:0] exp_resp);
        axil.awaddr  = a;
        axil.wdata   = d;
        axil.wstrb   = s;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.bready  = 1'b1;
        #1;
        chk("awready", axil.awready, 1);
        chk("wready", axil.wready, 1);
        tick();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        chk("wen", wen, exp_wen);
        chk("wr_addr", addr, {a[31:2], 2'b00});
        chk("wr_data", wdata, d);
        tick();
        chk("wen_off", wen, 0);
        chk("bvalid", axil.bvalid, 1);
        chk("bresp", axil.bresp, exp_resp);
        tick();
        chk("bvalid_off", axil.bvalid, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp);
        axil.araddr  = a;
        axil.arvalid = 1'b1;
        axil.rready  = 1'b1;
        #1;
        chk("arready", axil.arready, 1);
        tick();
        axil.arvalid = 1'b0;
        chk("rd_addr", addr, {a[31:2], 2'b00});
        chk("rvalid_t1", axil.rvalid, 0);
        tick();
        chk("rvalid_t2", axil.rvalid, 0);
        tick();
        chk("rvalid_t3", axil.rvalid, 1);
        chk("rdata", axil.rdata, exp_d);
        chk("rresp", axil.rresp, exp_resp);
        tick();
        chk("rvalid_off", axil.rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int r0;
        axil.awaddr  = 32'h0;
        axil.awvalid = 1'b1;
        axil.wdata   = 32'h0;
        axil.wstrb   = 4'hF;
        axil.wvalid  = 1'b1;
        axil.bready  = 1'b0;
        axil.araddr  = 32'h0;
        axil.arvalid = 1'b1;
        axil.rready  = 1'b0;

        #12;
        chk("rst_awready", axil.awready, 0);
        chk("rst_arready", axil.arready, 0);
        chk("rst_bvalid", axil.bvalid, 0);
        chk("rst_rvalid", axil.rvalid, 0);
        chk("rst_wen", wen, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rdata", axil.rdata, 0);
        chk("rst_bresp", axil.bresp, 0);
        chk("rst_rresp", axil.rresp, 0);
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_read(32'h28, 32'h3F, 2'b00);
        do_write(32'h24, 32'h3F, 4'hF, 1'b1, 2'b00);
        chk("bank_24", mem[9], 32'h3F);
        do_read(32'h24, 32'h3F, 2'b00);
        do_write(32'h40, 32'h77, 4'hF, 1'b0, 2'b10);
        do_write(32'h20, 32'hAA, 4'h3, 1'b0, 2'b10);
        chk("bank_20", mem[8], 32'h0);
        do_read(32'h44, 32'h0, 2'b10);

        // Collisions: reset so the last-grant flag starts at read.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        b0 = bcnt;
        r0 = rcnt;
        axil.awaddr  = 32'h30;
        axil.wdata   = 32'h55;
        axil.wstrb   = 4'hF;
        axil.araddr  = 32'h30;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.arvalid = 1'b1;
        axil.bready  = 1'b1;
        axil.rready  = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            int n = 0;
            while (!(axil.awready || axil.arready) && n < 12) begin
                tick();
                n++;
            end
            chk("grant_seen", 32'(n < 12), 1);
            chk("grant_w", axil.awready, 32'(g % 2 == 0));
            chk("grant_r", axil.arready, 32'(g % 2 == 1));
            tick();
        end
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("coll_bcnt", bcnt - b0, 2);
        chk("coll_rcnt", rcnt - r0, 2);
        chk("bank_30", mem[12], 32'h55);

        axil.awaddr  = 32'h18;
        axil.wdata   = 32'h1234;
        axil.wstrb   = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b0;
        axil.bready  = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("aw_only_awready", axil.awready, 0);
            chk("aw_only_wready", axil.wready, 0);
            tick();
        end
        axil.wvalid = 1'b1;
        #1;
        chk("aw_w_awready", axil.awready, 1);
        chk("aw_w_wready", axil.wready, 1);
        tick();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        chk("late_w_wen", wen, 1);
        tick();
        axil.araddr  = 32'h18;
        axil.arvalid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_bvalid", axil.bvalid, 1);
            chk("hold_bresp", axil.bresp, 0);
            chk("hold_arready", axil.arready, 0);
            tick();
        end
        axil.arvalid = 1'b0;
        axil.bready  = 1'b1;
        tick();
        chk("hold_release", axil.bvalid, 0);
        chk("bank_18", mem[6], 32'h1234);

        axil.awaddr  = 32'h1C;
        axil.wdata   = 32'hDEAD;
        axil.wstrb   = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.bready  = 1'b1;
        tick();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        chk("strobe_before_rst", wen, 1);
        rst_n = 1'b0;
        #1;
        chk("wrst_wen", wen, 0);
        chk("wrst_addr", addr, 0);
        chk("wrst_wdata", wdata, 0);
        tick();
        chk("wrst_bvalid", axil.bvalid, 0);
        rst_n = 1'b1;
        tick();
        chk("bank_1c", mem[7], 32'h0);
        do_write(32'h14, 32'hCAFE, 4'hF, 1'b1, 2'b00);
        chk("bank_14", mem[5], 32'hCAFE);

        axil.araddr  = 32'h14;
        axil.arvalid = 1'b1;
        axil.rready  = 1'b0;
        tick();
        axil.arvalid = 1'b0;
        tick();
        tick();
        chk("rresp_before_rst", axil.rvalid, 1);
        chk("rdata_before_rst", axil.rdata, 32'hCAFE);
        rst_n = 1'b0;
        #1;
        chk("rrst_rvalid", axil.rvalid, 0);
        chk("rrst_rdata", axil.rdata, 0);
        chk("rrst_addr", addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h14, 32'hCAFE, 2'b00);
        chk("wen_in_reset", wen_in_rst, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
